// File: rtl/mux1hot_pkg.sv
// Shared types and helpers for the one-hot mux pipeline.
//   skid_state_e : occupancy of the 2-entry output skid buffer
//   onehot_ok    : 1 when exactly one select bit is set
//   onehot_enc   : binary index of the lowest set select bit (0 when none set)
// Selects are passed zero-extended to SEL_MAX bits so that one function
// serves every N up to SEL_MAX.
package mux1hot_pkg;

  localparam int unsigned SEL_MAX = 64;

  typedef logic [SEL_MAX-1:0] sel_vec_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic logic onehot_ok(input sel_vec_t sel);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < SEL_MAX; i++) begin
      if (sel[i]) ones++;
    end
    return (ones == 1);
  endfunction

  function automatic int unsigned onehot_enc(input sel_vec_t sel);
    int unsigned idx;
    idx = 0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int unsigned i = SEL_MAX; i > 0; i--) begin
      if (sel[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux1hot_skid.sv
// Generic 2-entry skid buffer with fully registered outputs.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake; in_ready is a register
//   in_data  [W-1:0]     : payload pushed on in_valid && in_ready
//   out_valid / out_ready: downstream handshake; out_valid is a register
//   out_data [W-1:0]     : payload held in the main entry
// in_ready is computed from the next state, so there is no combinational
// path from out_ready to in_ready while 1 beat/cycle throughput is kept.
module mux1hot_skid
  import mux1hot_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, valid_q;
  logic         push, pop;

  assign push = in_valid && ready_q;
  assign pop  = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end else if (push) begin
          skid_d  = in_data;
          state_d = SKID_TWO;
        end
      end
      SKID_TWO: begin
        // ready_q is low here, so only a pop can happen.
        if (pop) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != SKID_TWO);
      valid_q <= (state_d != SKID_EMPTY);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/mux1hot_pipe.sv
// N-input one-hot AND-OR mux feeding a registered 2-entry skid buffer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready registered)
//   in_data [N*WIDTH]   : input i at in_data[i*WIDTH +: WIDTH]
//   in_sel  [N]         : one-hot select, qualified by in_valid
//   out_valid/out_ready : output handshake
//   out_data [WIDTH]    : selected data
//   out_idx             : index of lowest set select bit
//   err                 : 1-cycle pulse after an illegal select is accepted
//   err_cnt [CNT_W]     : saturating count of illegal selects
// Build option MUX1HOT_PIPE_SELCHK_EN: when defined, accepted beats whose
// select is not one-hot are consumed but dropped and reported on err/err_cnt;
// when undefined every accepted beat is forwarded and err/err_cnt are 0.
module mux1hot_pipe
  import mux1hot_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 err,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned PAY_W = IDX_W + WIDTH;

  logic [WIDTH-1:0] mux_data;
  logic [IDX_W-1:0] mux_idx;
  logic             sel_legal;
  logic             skid_in_valid;
  logic [PAY_W-1:0] pay_in, pay_out;

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_sel[i]) mux_data = mux_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  assign mux_idx = IDX_W'(onehot_enc(sel_vec_t'(in_sel)));

`ifdef MUX1HOT_PIPE_SELCHK_EN
  logic             accept;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;

  assign sel_legal = onehot_ok(sel_vec_t'(in_sel));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= accept && !sel_legal;
      if (accept && !sel_legal && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  assign sel_legal = 1'b1;
  assign err       = 1'b0;
  assign err_cnt   = '0;
`endif

  // in_ready comes straight from the skid; an illegal beat still completes
  // its upstream handshake but never enters the buffer.
  assign skid_in_valid = in_valid && sel_legal;
  assign pay_in        = {mux_idx, mux_data};

  mux1hot_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (skid_in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_idx, out_data} = pay_out;

endmodule

// File: tb/tb_mux1hot_pipe.sv
module tb_mux1hot_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = $clog2(N);
`ifdef MUX1HOT_PIPE_SELCHK_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 8;
`endif

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               err;
  logic [CNT_W-1:0]   err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t            q[$];
  logic             exp_err;
  logic [CNT_W-1:0] exp_cnt;

  mux1hot_pipe #(
    .WIDTH (WIDTH),
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: OR of all selected inputs; index of lowest selected input.
  function automatic logic [WIDTH-1:0] ref_data(input logic [N-1:0] sel, input logic [N*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (sel[i]) r = r | d[i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] ref_idx(input logic [N-1:0] sel);
    for (int i = 0; i < N; i++) if (sel[i]) return IDX_W'(i);
    return '0;
  endfunction

  // Queue model: up to two beats in flight; ready while fewer than two held.
  task automatic tick();
    bit    acc, emt, legal;
    beat_t b;
    acc = in_valid && (q.size() < 2);
    emt = out_ready && (q.size() > 0);
`ifdef MUX1HOT_PIPE_SELCHK_EN
    legal = $onehot(in_sel);
`else
    legal = 1'b1;
`endif
    b.data = ref_data(in_sel, in_data);
    b.idx  = ref_idx(in_sel);
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_err = 1'b0;
      exp_cnt = '0;
    end else begin
      if (emt) void'(q.pop_front());
      if (acc && legal) q.push_back(b);
      exp_err = acc && !legal;
      if (exp_err && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [N-1:0] sel, input bit ordy);
    in_valid  = v;
    in_sel    = sel;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'b0001, 1'b0);
    in_data = 32'hA5A5_A5A5;
    tick();
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (out_data !== '0 || out_idx !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h/%0d expected 00/0", out_data, out_idx); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got rdy=%b vld=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] want;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, N'(1 << k), 1'b1);
      tick();
      want = WIDTH'((k + 1) * 8'h11);
      n_checks++; if (out_valid !== 1'b1 || out_data !== want) begin n_fail++; $display("FAIL stream_data[%0d]: got vld=%b %h expected 1 %h", k, out_valid, out_data, want); end
      n_checks++; if (out_idx !== IDX_W'(k)) begin n_fail++; $display("FAIL stream_idx[%0d]: got %0d expected %0d", k, out_idx, k); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, in_ready); end
    end
    drive(1'b0, '0, 1'b1);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b1, 4'b0001, 1'b0); tick();
    n_checks++; if (in_ready !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL bp_first: got rdy=%b %h expected 1 11", in_ready, out_data); end
    drive(1'b1, 4'b0010, 1'b0); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b expected 0", in_ready); end
    drive(1'b1, 4'b0100, 1'b0); tick();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL bp_hold: got rdy=%b vld=%b %h expected 0 1 11", in_ready, out_valid, out_data); end
    drive(1'b1, 4'b0100, 1'b1); tick();
    n_checks++; if (out_data !== 8'h22 || out_idx !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_emit1: got %h/%0d rdy=%b expected 22/1 1", out_data, out_idx, in_ready); end
    tick();
    n_checks++; if (out_data !== 8'h33 || out_idx !== 2'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_emit2: got %h/%0d vld=%b expected 33/2 1", out_data, out_idx, out_valid); end
    drive(1'b0, '0, 1'b1); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_select();
`ifdef MUX1HOT_PIPE_SELCHK_EN
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b1, 4'b0000, 1'b1); tick();
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 2'd1) begin n_fail++; $display("FAIL selchk_zero: got err=%b vld=%b cnt=%0d expected 1 0 1", err, out_valid, err_cnt); end
    drive(1'b1, 4'b0110, 1'b1); tick();
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 2'd2) begin n_fail++; $display("FAIL selchk_multi: got err=%b vld=%b cnt=%0d expected 1 0 2", err, out_valid, err_cnt); end
    drive(1'b0, '0, 1'b1); tick();
    n_checks++; if (err !== 1'b0 || err_cnt !== 2'd2) begin n_fail++; $display("FAIL selchk_idle: got err=%b cnt=%0d expected 0 2", err, err_cnt); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'b1111, 1'b1); tick();
    end
    drive(1'b0, '0, 1'b1); tick();
    n_checks++; if (err_cnt !== 2'd3 || out_valid !== 1'b0) begin n_fail++; $display("FAIL selchk_sat: got cnt=%0d vld=%b expected 3 0", err_cnt, out_valid); end
`else
    in_data = {8'h00, 8'hF0, 8'h0F, 8'h00};
    drive(1'b1, 4'b0110, 1'b1); tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL multihot_data: got vld=%b %h expected 1 ff", out_valid, out_data); end
    n_checks++; if (out_idx !== 2'd1 || err !== 1'b0 || err_cnt !== '0) begin n_fail++; $display("FAIL multihot_idx: got idx=%0d err=%b cnt=%0d expected 1 0 0", out_idx, err, err_cnt); end
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b1, 4'b0000, 1'b1); tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_idx !== 2'd0) begin n_fail++; $display("FAIL zerosel: got vld=%b %h/%0d expected 1 00/0", out_valid, out_data, out_idx); end
    drive(1'b0, '0, 1'b1); tick();
`endif
  endtask

  task automatic test_midreset();
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b1, 4'b0001, 1'b0); tick();
    drive(1'b1, 4'b0010, 1'b0); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_two: got rdy=%b expected 0", in_ready); end
    rst = 1'b1;
    drive(1'b1, 4'b0100, 1'b1); tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst: got vld=%b rdy=%b expected 0 1", out_valid, in_ready); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got vld=%b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] sel;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) sel = N'($urandom);
      else sel = N'(1 << $urandom_range(N - 1));
      in_data = (N*WIDTH)'($urandom);
      drive($urandom_range(3) != 0, sel, $urandom_range(3) != 0);
      tick();
      n_checks++; if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, in_ready, q.size() < 2); end
      n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_checks++; if (out_data !== q[0].data || out_idx !== q[0].idx) begin n_fail++; $display("FAIL rnd_beat@%0d: got %h/%0d expected %h/%0d", c, out_data, out_idx, q[0].data, q[0].idx); end
      end
      n_checks++; if (err !== exp_err || err_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_err@%0d: got %b/%0d expected %b/%0d", c, err, err_cnt, exp_err, exp_cnt); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = '0;
    #2;
    test_reset();
    test_streaming();
    test_back_to_back();
    test_select();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
